// File: rtl/combo_lock_ctrl.sv
// Sequencing FSM for the digital combination lock: attempt tracking, DENIED hold,
// lockout countdown. Define COMBO_LOCK_AUTO_RELOCK_EN to return from OPEN after RELOCK_SEC.
module combo_lock_ctrl #(
    parameter int                CODE_W      = 6,
    parameter logic [CODE_W-1:0] PASSCODE    = 6'b101001,
    parameter int                MAX_TRIES   = 3,
    parameter int                CLK_HZ      = 50_000_000,
    parameter int                DENY_SEC    = 5,
    parameter int                LOCKOUT_SEC = 55,
    parameter int                RELOCK_SEC  = 10
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic                             submit,
    input  logic [CODE_W-1:0]                code_in,
    output logic [2:0]                       disp_mode,
    output logic [$clog2(MAX_TRIES+1)-1:0]   attempts_left,
    output logic [5:0]                       lockout_sec,
    output logic                             unlocked
);

    localparam int AW      = $clog2(MAX_TRIES + 1);
    localparam int PW      = $clog2(CLK_HZ);
    localparam int SEC_MAX = (DENY_SEC > RELOCK_SEC) ? DENY_SEC : RELOCK_SEC;
    localparam int SEC_W   = $clog2(SEC_MAX + 1);

    // Encodings double as the display mode, so disp_mode is the state register itself.
    typedef enum logic [2:0] {
        CLOSED = 3'd0,
        ENTRY  = 3'd1,
        OPEN   = 3'd2,
        DENIED = 3'd3,
        COUNT  = 3'd4
    } state_t;

    state_t           state;
    logic [PW-1:0]    presc;
    logic [SEC_W-1:0] sec_cnt;
    logic             submit_q;
    logic             tick;
    logic             sub_edge;

    assign tick      = (presc == PW'(CLK_HZ - 1));
    assign sub_edge  = submit & ~submit_q;
    assign disp_mode = state;

    // submit_q resets high so a switch held through reset never counts as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= CLOSED;
            attempts_left <= AW'(MAX_TRIES);
            lockout_sec   <= '0;
            unlocked      <= 1'b0;
            presc         <= '0;
            sec_cnt       <= '0;
            submit_q      <= 1'b1;
        end else begin
            submit_q <= submit;
            presc    <= tick ? '0 : presc + 1'b1;
            case (state)
                CLOSED: begin
                    if (en) begin
                        state         <= ENTRY;
                        attempts_left <= AW'(MAX_TRIES);
                    end
                end
                ENTRY: begin
                    if (!en) begin
                        state <= CLOSED;
                    end else if (sub_edge) begin
                        if (code_in == PASSCODE) begin
                            state    <= OPEN;
                            unlocked <= 1'b1;
                            presc    <= '0;
                            sec_cnt  <= '0;
                        end else if (attempts_left > AW'(1)) begin
                            attempts_left <= attempts_left - 1'b1;
                        end else begin
                            state         <= DENIED;
                            attempts_left <= '0;
                            presc         <= '0;
                            sec_cnt       <= '0;
                        end
                    end
                end
                OPEN: begin
                    if (!en) begin
                        state         <= CLOSED;
                        unlocked      <= 1'b0;
                        attempts_left <= AW'(MAX_TRIES);
                    end
`ifdef COMBO_LOCK_AUTO_RELOCK_EN
                    else if (tick) begin
                        if (sec_cnt == SEC_W'(RELOCK_SEC - 1)) begin
                            state         <= ENTRY;
                            unlocked      <= 1'b0;
                            attempts_left <= AW'(MAX_TRIES);
                            sec_cnt       <= '0;
                        end else begin
                            sec_cnt <= sec_cnt + 1'b1;
                        end
                    end
`endif
                end
                DENIED: begin
                    if (tick) begin
                        if (sec_cnt == SEC_W'(DENY_SEC - 1)) begin
                            state       <= COUNT;
                            lockout_sec <= 6'(LOCKOUT_SEC);
                            sec_cnt     <= '0;
                        end else begin
                            sec_cnt <= sec_cnt + 1'b1;
                        end
                    end
                end
                COUNT: begin
                    // The zero value is shown for a full second before the exit tick.
                    if (tick) begin
                        if (lockout_sec == 6'd0) begin
                            state         <= en ? ENTRY : CLOSED;
                            attempts_left <= AW'(MAX_TRIES);
                        end else begin
                            lockout_sec <= lockout_sec - 1'b1;
                        end
                    end
                end
                default: begin
                    state <= CLOSED;
                end
            endcase
        end
    end

endmodule
